imem_axil_rd_slave: RTL and testbench
=====================================

Name: imem_axil_rd_slave

Overview:
- AXI-lite read-channel slave serving instruction fetches from the fetch stage's AR/R master port; sits directly upstream of the fetch stage.
- Accepts one read address at a time and inserts a fixed or pseudo-random latency to stress the fetch handshake.
- Reads a 64-bit word from a synchronous backing SRAM port and returns it with an RRESP code.
- Detects misaligned and out-of-range fetches.

Parameters:
- ADDR_W, 32: AR address width, matches the memory address bus.
- DATA_W, 64: RDATA width, matches the memory data bus.
- MEM_BASE, 32'h8000_0000: first byte address of the imem window.
- MEM_WORDS, 16384: number of DATA_W words in the window.
- LAT_RANDOM, 0: 0 selects fixed latency; 1 selects LFSR-driven latency.
- FIXED_LAT, 2: extra wait cycles when LAT_RANDOM=0, range 0..15.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit LFSR, must be nonzero.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset, asynchronous, active-high. One clock; all state clears on rst assertion without waiting for a clk edge.
- ARVALID  in  1  Read address valid from the fetch stage.
- ARADDR  in  ADDR_W  Fetch byte address.
- ARREADY  out  1  Slave can accept an address.
- RVALID  out  1  Read data valid.
- RDATA  out  DATA_W  Read word.
- RRESP  out  2  00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range).
- RREADY  in  1  Master accepts read data.
- mem_req  out  1  Backing SRAM read strobe.
- mem_addr  out  $clog2(MEM_WORDS)  Word index.
- mem_rdata  in  DATA_W  SRAM data, valid the cycle after mem_req.
- rd_count  out  32  Number of completed R handshakes, wraps.

Behaviour:
- Reset values: ARREADY=0 while rst is asserted and 1 in the first cycle after release; RVALID=0, RDATA=0, RRESP=00, mem_req=0, rd_count=0, LFSR=LFSR_SEED, state=IDLE.
- States: IDLE, WAIT, MEM, RESP.
- ARREADY = (state==IDLE) and not rst.
- IDLE: on ARVALID&ARREADY, latch ARADDR and load the wait counter with FIXED_LAT, or with LFSR[3:0] when LAT_RANDOM=1. Go to WAIT.
- Address classification at capture:
  - misaligned when ARADDR[1:0]!=0 -> SLVERR;
  - out of range when ARADDR<MEM_BASE or ARADDR>=MEM_BASE+8*MEM_WORDS -> DECERR;
  - misaligned takes priority over out of range;
  - otherwise OKAY.
- WAIT: when counter==0, go to MEM; otherwise decrement. A loaded value of 0 spends exactly one cycle in WAIT.
- MEM, OKAY case:
  - mem_req=1 for exactly one cycle;
  - mem_addr=(addr-MEM_BASE)>>3, with the subtraction done in ADDR_W bits;
  - next edge: RDATA<=mem_rdata, RRESP<=00, RVALID<=1, go to RESP.
- MEM, error case: mem_req stays 0; RDATA<=0 and RRESP<=error code; RVALID<=1; go to RESP.
- RDATA carries the full 64-bit word. The fetch stage selects the 32-bit half using address bit 2.
- RESP:
  - RVALID, RDATA and RRESP hold stable until RVALID&RREADY;
  - on that handshake: RVALID<=0, rd_count<=rd_count+1 (wraps at 2^32), go to IDLE.
- Latency: with handshake in cycle T, RVALID first rises in cycle T+3+lat. Maximum throughput is one transfer per lat+4 cycles.
- ARVALID while not IDLE is ignored; the master must hold it per AXI rules. RREADY outside RESP has no effect.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle out of reset regardless of state.
- Reset mid-operation (any state): immediate return to reset values; the in-flight transfer is dropped and mem_req deasserts asynchronously.
- Address wrap: MEM_BASE+8*MEM_WORDS is computed at ADDR_W+1 bits so a window ending at 2^32 does not wrap.

Decomposition:
- Shared defines file gets:
  - RRESP codes (RESP_OKAY, RESP_SLVERR, RESP_DECERR);
  - state encoding localparams;
  - MemAddrBus/MemDataBus widths, which are already shared.
- One sub-module, lat_lfsr: 16-bit LFSR with seed parameter and async reset, output lfsr[15:0].
- Counter and FSM live in the top module.

Test Plan:
- Single aligned fetch: FIXED_LAT=2, mem word[0]=64'h0000_0013_0000_0297, ARADDR=32'h8000_0000, RREADY=1 -> ARREADY handshake at T; mem_req at T+3 with mem_addr=0; RVALID at T+5 with that RDATA and RRESP=00; rd_count=1.
- Backpressure: RREADY=0 for 6 cycles after RVALID -> RVALID/RDATA/RRESP stable all 6 cycles, ARREADY=0 throughout; completes when RREADY=1; next AR accepted the following cycle.
- Errors:
  - ARADDR=32'h8000_0002 -> RRESP=10, RDATA=0, no mem_req;
  - ARADDR=32'h7FFF_FFFC -> RRESP=11;
  - ARADDR=MEM_BASE+8*MEM_WORDS -> RRESP=11.
- Back-to-back streaming: 100 sequential fetches from 32'h8000_0000, step 4, LAT_RANDOM=1, RREADY always 1 -> every RDATA matches the model word at addr>>3; per-transfer latency stays within 3..18 cycles after handshake; rd_count=100.
- Async reset mid-transfer: assert rst during WAIT, then again during RESP with RREADY=0 -> RVALID and mem_req drop before the next clk edge; ARREADY=1 one cycle after release; rd_count=0; the old transfer never reappears.

Source files
------------

// File: rtl/imem_axil_rd_slave_pkg.sv
// Shared definitions for the imem AXI-lite read slave: response codes, FSM encoding, bus widths.
package imem_axil_rd_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int MEM_ADDR_BUS_W = 14;
    localparam int MEM_DATA_BUS_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MEM  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/imem_axil_rd_slave_if.sv
// AXI-lite read-channel bundle between the fetch stage (master) and the imem slave.
interface imem_axil_rd_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              ARVALID;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARREADY;
    logic              RVALID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RREADY;

    modport master (
        output ARVALID, ARADDR, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/imem_axil_rd_slave_lat_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to randomise fetch latency; free-runs out of reset.
module lat_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;
endmodule

// File: rtl/imem_axil_rd_slave.sv
// AXI-lite read slave feeding the instruction fetch stage from a synchronous imem SRAM.
// Each fetch waits a fixed or LFSR-chosen number of cycles; bad addresses answer SLVERR/DECERR.
module imem_axil_rd_slave
    import imem_axil_rd_slave_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = MEM_DATA_BUS_W,
    parameter logic [ADDR_W-1:0] MEM_BASE   = 32'h8000_0000,
    parameter int                MEM_WORDS  = 1 << MEM_ADDR_BUS_W,
    parameter int                LAT_RANDOM = 0,
    parameter int                FIXED_LAT  = 2,
    parameter logic [15:0]       LFSR_SEED  = 16'hACE1,
    localparam int               MEM_AW     = $clog2(MEM_WORDS)
) (
    input  logic                clk,
    input  logic                rst,
    imem_axil_rd_slave_if.slave axi,
    output logic                mem_req,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [31:0]         rd_count
);
    // Window end is one bit wider so a window ending at 2^ADDR_W does not wrap to zero.
    localparam int               END_W       = ADDR_W + 1;
    localparam logic [END_W-1:0] MEM_END     = {1'b0, MEM_BASE} + END_W'(64'(MEM_WORDS) * 64'd8);
    localparam logic [3:0]       FIXED_LAT_V = 4'(FIXED_LAT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          err_q, err_d;
    logic [3:0]          wait_q, wait_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [31:0]         rd_count_q, rd_count_d;

    logic                arready;
    logic                misaligned;
    logic                out_of_range;
    logic [1:0]          ar_code;
    logic [3:0]          lat_load;
    logic [15:0]         lfsr;
    logic                lfsr_unused;

    lat_lfsr #(.SEED(LFSR_SEED)) u_lat_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    assign lat_load     = (LAT_RANDOM != 0) ? lfsr[3:0] : FIXED_LAT_V;
    assign lfsr_unused  = ^lfsr[15:4];
    assign misaligned   = (axi.ARADDR[1:0] != 2'b00);
    assign out_of_range = (axi.ARADDR < MEM_BASE) || ({1'b0, axi.ARADDR} >= MEM_END);

    always_comb begin
        if (misaligned) begin
            ar_code = RESP_SLVERR;
        end else if (out_of_range) begin
            ar_code = RESP_DECERR;
        end else begin
            ar_code = RESP_OKAY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            err_q      <= RESP_OKAY;
            wait_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_count_q <= rd_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        err_d      = err_q;
        wait_d     = wait_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_count_d = rd_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (axi.ARVALID && arready) begin
                    addr_d  = axi.ARADDR;
                    err_d   = ar_code;
                    wait_d  = lat_load;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_MEM;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            // SRAM word requested on the last wait cycle is on mem_rdata now.
            ST_MEM: begin
                rvalid_d = 1'b1;
                rdata_d  = (err_q == RESP_OKAY) ? mem_rdata : '0;
                rresp_d  = err_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (axi.RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_count_d = rd_count_q + 32'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The SRAM strobe leads the MEM state by one cycle because the macro has one cycle of read latency.
    always_comb begin
        arready  = (state_q == ST_IDLE) && !rst;
        mem_req  = (state_q == ST_WAIT) && (wait_q == 4'd0) && (err_q == RESP_OKAY);
        mem_addr = MEM_AW'((addr_q - MEM_BASE) >> 3);
    end

    assign axi.ARREADY = arready;
    assign axi.RVALID  = rvalid_q;
    assign axi.RDATA   = rdata_q;
    assign axi.RRESP   = rresp_q;
    assign rd_count    = rd_count_q;
endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Directed bench for imem_axil_rd_slave: one fixed-latency and one random-latency instance,
// expected read words queued at AR time and popped when R data appears.
module tb_imem_axil_rd_slave;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 16384;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [13:0] idx;
    } exp_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        arvalid = 1'b0;
    logic [31:0] araddr  = '0;
    logic        rready  = 1'b1;
    logic        use_b   = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    int          cnt_a    = 0;
    int          cnt_b    = 0;
    exp_t        sb[$];

    imem_axil_rd_slave_if #(.ADDR_W(32), .DATA_W(64)) if_a ();
    imem_axil_rd_slave_if #(.ADDR_W(32), .DATA_W(64)) if_b ();

    logic        mem_req_a, mem_req_b;
    logic [13:0] mem_addr_a, mem_addr_b;
    logic [63:0] mem_rdata_a = '0;
    logic [63:0] mem_rdata_b = '0;
    logic [31:0] rd_count_a, rd_count_b;

    logic        obs_arready, obs_rvalid, obs_mem_req;
    logic [63:0] obs_rdata;
    logic [1:0]  obs_rresp;
    logic [13:0] obs_mem_addr;
    logic [31:0] obs_rd_count;

    always #5 clk = ~clk;

    assign if_a.ARVALID = arvalid & ~use_b;
    assign if_a.ARADDR  = araddr;
    assign if_a.RREADY  = use_b ? 1'b1 : rready;
    assign if_b.ARVALID = arvalid & use_b;
    assign if_b.ARADDR  = araddr;
    assign if_b.RREADY  = use_b ? rready : 1'b1;

    assign obs_arready  = use_b ? if_b.ARREADY : if_a.ARREADY;
    assign obs_rvalid   = use_b ? if_b.RVALID  : if_a.RVALID;
    assign obs_rdata    = use_b ? if_b.RDATA   : if_a.RDATA;
    assign obs_rresp    = use_b ? if_b.RRESP   : if_a.RRESP;
    assign obs_mem_req  = use_b ? mem_req_b    : mem_req_a;
    assign obs_mem_addr = use_b ? mem_addr_b   : mem_addr_a;
    assign obs_rd_count = use_b ? rd_count_b   : rd_count_a;

    imem_axil_rd_slave #(.LAT_RANDOM(0), .FIXED_LAT(2)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .axi       (if_a),
        .mem_req   (mem_req_a),
        .mem_addr  (mem_addr_a),
        .mem_rdata (mem_rdata_a),
        .rd_count  (rd_count_a)
    );

    imem_axil_rd_slave #(.LAT_RANDOM(1), .FIXED_LAT(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .axi       (if_b),
        .mem_req   (mem_req_b),
        .mem_addr  (mem_addr_b),
        .mem_rdata (mem_rdata_b),
        .rd_count  (rd_count_b)
    );

    function automatic logic [63:0] memWord(input logic [13:0] idx);
        if (idx == 14'd0) return 64'h0000_0013_0000_0297;
        return {16'hC0DE, 2'b00, idx, 16'h5A00, 2'b11, ~idx};
    endfunction

    function automatic logic [1:0] classify(input logic [31:0] a);
        longint unsigned lo, hi, v;
        lo = 64'(BASE);
        hi = lo + 64'(WORDS) * 64'd8;
        v  = 64'(a);
        if (a[1:0] != 2'b00) return 2'b10;
        if (v < lo || v >= hi) return 2'b11;
        return 2'b00;
    endfunction

    // Synchronous SRAM models: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        mem_rdata_a <= mem_req_a ? memWord(mem_addr_a) : 64'hDEAD_BEEF_0BAD_F00D;
        mem_rdata_b <= mem_req_b ? memWord(mem_addr_b) : 64'hDEAD_BEEF_0BAD_F00D;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives an AR beat and returns at the negedge of the first cycle after the handshake.
    task automatic startFetch(input logic [31:0] addr, input logic rr);
        int k;
        arvalid = 1'b1;
        araddr  = addr;
        rready  = rr;
        k = 0;
        while (!obs_arready && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("ar_handshake", 64'(obs_arready), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input int lat_min, input int lat_max,
                                 input int hold);
        exp_t        e, got;
        int          k, req_cnt, req_k;
        logic [13:0] req_idx;
        e.resp = classify(addr);
        e.idx  = 14'((addr - BASE) >> 3);
        e.data = (e.resp == 2'b00) ? memWord(e.idx) : 64'd0;
        sb.push_back(e);
        startFetch(addr, (hold == 0));
        k       = 1;
        req_cnt = 0;
        req_k   = -1;
        req_idx = '0;
        while (!obs_rvalid && k < 40) begin
            if (obs_mem_req) begin
                req_cnt++;
                req_k   = k;
                req_idx = obs_mem_addr;
            end
            @(negedge clk);
            k++;
        end
        checkOutput("rvalid_seen", 64'(obs_rvalid), 64'd1);
        checkOutput("latency_in_range", 64'(k >= lat_min && k <= lat_max), 64'd1);
        got = sb.pop_front();
        checkOutput("mem_req_count", 64'(req_cnt), (got.resp == 2'b00) ? 64'd1 : 64'd0);
        if (got.resp == 2'b00) begin
            checkOutput("mem_req_timing", 64'(req_k), 64'(k - 2));
            checkOutput("mem_addr", 64'(req_idx), 64'(got.idx));
        end
        checkOutput("rdata", obs_rdata, got.data);
        checkOutput("rresp", 64'(obs_rresp), 64'(got.resp));
        for (int i = 0; i < hold; i++) begin
            checkOutput("bp_rvalid", 64'(obs_rvalid), 64'd1);
            checkOutput("bp_rdata", obs_rdata, got.data);
            checkOutput("bp_rresp", 64'(obs_rresp), 64'(got.resp));
            checkOutput("bp_arready", 64'(obs_arready), 64'd0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        if (use_b) cnt_b++; else cnt_a++;
        checkOutput("post_rvalid", 64'(obs_rvalid), 64'd0);
        checkOutput("post_arready", 64'(obs_arready), 64'd1);
        checkOutput("rd_count", 64'(obs_rd_count), use_b ? 64'(cnt_b) : 64'(cnt_a));
    endtask

    // Pulses reset mid-transfer, checks the asynchronous drop, then confirms nothing resurfaces.
    task automatic resetDuring(input string tag);
        int stray;
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rvalid_async"}, 64'(obs_rvalid), 64'd0);
        checkOutput({tag, "_mem_req_async"}, 64'(obs_mem_req), 64'd0);
        checkOutput({tag, "_arready_in_rst"}, 64'(obs_arready), 64'd0);
        checkOutput({tag, "_rdata_async"}, obs_rdata, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        rready = 1'b1;
        cnt_a  = 0;
        cnt_b  = 0;
        @(negedge clk);
        checkOutput({tag, "_arready_after"}, 64'(obs_arready), 64'd1);
        checkOutput({tag, "_rd_count_a"}, 64'(rd_count_a), 64'(cnt_a));
        checkOutput({tag, "_rd_count_b"}, 64'(rd_count_b), 64'(cnt_b));
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (obs_rvalid || obs_mem_req) stray++;
            @(negedge clk);
        end
        checkOutput({tag, "_no_ghost"}, 64'(stray), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        @(negedge clk);
        checkOutput("rst_arready", 64'(if_a.ARREADY), 64'd0);
        checkOutput("rst_rvalid", 64'(if_a.RVALID), 64'd0);
        checkOutput("rst_rdata", if_a.RDATA, 64'd0);
        checkOutput("rst_rresp", 64'(if_a.RRESP), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req_a), 64'd0);
        checkOutput("rst_rd_count", 64'(rd_count_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("arready_after_rst", 64'(if_a.ARREADY), 64'd1);

        $display("[TB] fixed-latency fetches");
        applyStimulus(BASE, 5, 5, 0);
        applyStimulus(BASE + 32'h4, 5, 5, 0);
        applyStimulus(BASE + 32'h8, 5, 5, 6);
        applyStimulus(BASE + 32'h0001_FFF8, 5, 5, 0);
        applyStimulus(BASE + 32'h0000_0128, 5, 5, 0);

        $display("[TB] error responses");
        applyStimulus(32'h8000_0002, 5, 5, 0);
        applyStimulus(32'h7FFF_FFFC, 5, 5, 0);
        applyStimulus(BASE + 32'(WORDS * 8), 5, 5, 0);
        applyStimulus(32'h7FFF_FFFE, 5, 5, 0);
        applyStimulus(32'h8002_0001, 5, 5, 2);

        $display("[TB] random-latency streaming");
        use_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(BASE + 32'(4 * i), 3, 18, 0);
        end
        checkOutput("stream_rd_count", 64'(rd_count_b), 64'd100);
        use_b = 1'b0;

        $display("[TB] reset mid-transfer");
        startFetch(BASE + 32'h10, 1'b1);
        resetDuring("rst_wait");

        startFetch(BASE + 32'h18, 1'b1);
        k = 0;
        while (!obs_mem_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("mem_req_before_rst", 64'(obs_mem_req), 64'd1);
        resetDuring("rst_memreq");

        startFetch(BASE + 32'h20, 1'b0);
        k = 0;
        while (!obs_rvalid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rvalid_before_rst", 64'(obs_rvalid), 64'd1);
        resetDuring("rst_resp");

        applyStimulus(BASE + 32'h20, 5, 5, 0);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
